// File: rtl/wb_byte_fifo_if.sv
// Wishbone classic slave bus bundle for wb_byte_fifo.
// The master modport drives requests; the slave modport returns data/ack.
interface wb_byte_fifo_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_byte_fifo.sv
// wb_byte_fifo: byte FIFO behind a Wishbone classic slave port.
// Register map (wb_adr_i[3:2]): 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
// Every access acks one cycle after the request and side effects happen on that same edge.
// Optional feature: define WB_BYTE_FIFO_OVF_EN to add a sticky overflow flag (STATUS[2]),
// set by writes dropped while full and cleared by CTRL bit 1.
module wb_byte_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DATA_W    = 8,
  parameter logic [7:0]  FILL_CHAR = 8'h41
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  wb_byte_fifo_if.slave  bus,
  output logic           irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FullCount = DEPTH[AW:0];
  localparam logic [AW:0]   CntOne    = 1;
  localparam logic [AW-1:0] PtrOne    = 1;

  localparam logic [1:0] AdrData   = 2'd0;
  localparam logic [1:0] AdrStatus = 2'd1;
  localparam logic [1:0] AdrCtrl   = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ack_q;
  logic [31:0]       dat_q, dat_d;
  logic [1:0]        rdy_sync_q;
  logic              ovf;

  logic       req, full, empty;
  logic       is_data, is_status, is_ctrl;
  logic       push, pop, drop, flush;
  logic [7:0] head8;
  logic [7:0] cnt8;
  logic [15:0] cnt_ext;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign irq_o = ~empty;

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;

  // Access decode; requests are held off until reset release has been synchronised.
  always_comb begin
    req       = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q & rdy_sync_q[1];
    is_data   = (bus.wb_adr_i[3:2] == AdrData);
    is_status = (bus.wb_adr_i[3:2] == AdrStatus);
    is_ctrl   = (bus.wb_adr_i[3:2] == AdrCtrl);
    push      = req & bus.wb_we_i & is_data & bus.wb_sel_i[0] & ~full;
    drop      = req & bus.wb_we_i & is_data & bus.wb_sel_i[0] & full;
    pop       = req & ~bus.wb_we_i & is_data & ~empty;
    flush     = req & bus.wb_we_i & is_ctrl & bus.wb_dat_i[0];
  end

  // Head entry zero-extended to a byte; count clamped to the 8-bit STATUS field.
  always_comb begin
    head8 = '0;
    head8[DATA_W-1:0] = mem[rd_ptr_q];
    cnt_ext = 16'(count_q);
    cnt8 = (cnt_ext > 16'd255) ? 8'hFF : cnt_ext[7:0];
  end

  // Pointer and occupancy next-state; push, pop and flush are mutually exclusive.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
      count_d  = count_q + CntOne;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      count_d  = count_q - CntOne;
    end
  end

  // Read data mux; the output register only changes when a read completes.
  always_comb begin
    dat_d = dat_q;
    if (req && !bus.wb_we_i) begin
      dat_d = 32'h0;
      if (is_data) begin
        dat_d = empty ? {4{FILL_CHAR}} : {4{head8}};
      end else if (is_status) begin
        dat_d = {8'h00, cnt8, 13'h0, ovf, full, empty};
      end
    end
  end

  // Reset release synchroniser: assert is asynchronous, deassert takes two clocks.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rdy_sync_q <= 2'b00;
    end else begin
      rdy_sync_q <= {rdy_sync_q[0], 1'b1};
    end
  end

  // Bus handshake, read data and FIFO bookkeeping state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ack_q    <= req;
      dat_q    <= dat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.wb_dat_i[DATA_W-1:0];
    end
  end

`ifdef WB_BYTE_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: set by a dropped write, cleared only by CTRL bit 1 (not by flush).
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (req && bus.wb_we_i && is_ctrl && bus.wb_dat_i[1]) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Bus fields this slave never looks at.
  logic unused_bits;
  assign unused_bits = ^{bus.wb_adr_i[31:4], bus.wb_adr_i[1:0], bus.wb_dat_i[31:DATA_W],
                         bus.wb_sel_i[3:1], bus.wb_cti_i, bus.wb_bte_i, drop};

endmodule

// File: tb/tb_wb_byte_fifo.sv
// Directed bench for wb_byte_fifo (DEPTH=16, DATA_W=8, FILL_CHAR=8'h41).
// A queue model holds the expected FIFO contents; reads pop and compare against it.
module tb_wb_byte_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  always #5 clk = ~clk;

  wb_byte_fifo_if bus ();

  wb_byte_fifo #(
    .DEPTH     (16),
    .DATA_W    (8),
    .FILL_CHAR (8'h41)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus.slave),
    .irq_o     (irq)
  );

`ifdef WB_BYTE_FIFO_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];
  logic       ovf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    logic [7:0] c;
    c = 8'(exp_q.size());
    return {8'h00, c, 13'h0, ovf_m, exp_q.size() == 16, exp_q.size() == 0};
  endfunction

  // One classic access; checks ack arrives within a bound and lasts one cycle.
  task automatic bus_cycle(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, output logic [31:0] rdat);
    int n;
    @(posedge clk);
    #1;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.wb_ack_o && n < 8);
    if (!bus.wb_ack_o) check("ack_timeout", {31'h0, bus.wb_ack_o}, 32'h1);
    rdat = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
    check("ack_one_cycle", {31'h0, bus.wb_ack_o}, 32'h0);
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel = 4'hF);
    logic [31:0] r;
    if (adr[3:2] == 2'd0 && sel[0]) begin
      if (exp_q.size() < 16) exp_q.push_back(dat[7:0]);
      else if (OvfEn) ovf_m = 1'b1;
    end else if (adr[3:2] == 2'd2) begin
      if (dat[0]) exp_q.delete();
      if (dat[1]) ovf_m = 1'b0;
    end
    bus_cycle(adr, dat, sel, 1'b1, r);
  endtask

  task automatic do_read(input string tag, input logic [31:0] adr);
    logic [31:0] exp, r;
    case (adr[3:2])
      2'd0: begin
        if (exp_q.size() != 0) exp = {4{exp_q.pop_front()}};
        else exp = 32'h41414141;
      end
      2'd1: exp = status_exp();
      default: exp = 32'h0;
    endcase
    bus_cycle(adr, 32'h0, 4'hF, 1'b0, r);
    check(tag, r, exp);
  endtask

  initial begin
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cti_i = 3'b111;
    bus.wb_bte_i = 2'b01;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
    check("rst_dat", bus.wb_dat_o, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Empty read returns fill, status empty.
    do_read("empty_data", 32'h0);
    check("empty_status_const", status_exp(), 32'h00000001);
    do_read("empty_status", 32'h4);

    // Three pushes, then drain.
    do_write(32'h0, 32'h11);
    do_write(32'h0, 32'h22);
    do_write(32'h0, 32'h33);
    do_read("three_status", 32'h4);
    check("three_irq", {31'h0, irq}, 32'h1);
    for (int i = 0; i < 4; i++) do_read($sformatf("drain3_%0d", i), 32'h0);
    check("drain3_irq", {31'h0, irq}, 32'h0);

    // Overfill with 17 bytes.
    for (int i = 0; i < 17; i++) do_write(32'h0, i);
    do_read("full_status", 32'h4);
    for (int i = 0; i < 16; i++) do_read($sformatf("full_rd_%0d", i), 32'h0);
    do_write(32'h8, 32'h2);
    do_read("ovf_clr_status", 32'h4);

    // Wrap-around.
    for (int i = 0; i < 10; i++) do_write(32'h0, 8'h80 + i);
    for (int i = 0; i < 10; i++) do_read($sformatf("wrap_a_%0d", i), 32'h0);
    for (int i = 0; i < 12; i++) do_write(32'h0, 8'hC0 + i);
    for (int i = 0; i < 12; i++) do_read($sformatf("wrap_b_%0d", i), 32'h0);
    do_read("wrap_status", 32'h4);

    // Flush, then masked-lane write.
    for (int i = 0; i < 5; i++) do_write(32'h0, 8'h50 + i);
    do_write(32'h8, 32'h1);
    do_read("flush_status", 32'h4);
    do_read("flush_data", 32'h0);
    do_write(32'h0, 32'h77, 4'b1110);
    do_read("sel_status", 32'h4);

    // Flush leaves the overflow flag alone; CTRL bit 1 clears it.
    for (int i = 0; i < 17; i++) do_write(32'h0, 8'hA0 + i);
    do_write(32'h8, 32'h1);
    do_read("flush_keep_ovf", 32'h4);
    do_write(32'h8, 32'h2);
    do_read("ovf_clr2", 32'h4);

    // Reserved address reads zero, writes ignored.
    do_write(32'hC, 32'hFFFF_FFFF);
    do_read("reserved", 32'hC);
    do_read("reserved_status", 32'h4);

    // Reset pulsed in the middle of an access with 4 entries stored.
    for (int i = 0; i < 4; i++) do_write(32'h0, 8'h60 + i);
    @(posedge clk);
    #1;
    bus.wb_adr_i = 32'h0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid_ack", {31'h0, bus.wb_ack_o}, 32'h0);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    ovf_m = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    do_read("rst_mid_status", 32'h4);
    do_read("rst_mid_data", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout observed=running expected=finished");
  end
endmodule
